// File: rtl/sm_reg_scanner_pkg.sv
// rtl/sm_reg_scanner_pkg.sv - shared state encoding for the debug register scanner
package sm_reg_scanner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } scanState_t;

endpackage

// File: rtl/sm_reg_scanner.sv
// rtl/sm_reg_scanner.sv - walks CPU debug register indices and streams {addr,data} beats
module sm_reg_scanner
  import sm_reg_scanner_pkg::*;
#(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int REG_FIRST = 0,
  parameter int REG_LAST  = 31,
  parameter int READ_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] regAddr,
  input  logic [DATA_W-1:0] regData,
  output logic              outValid,
  input  logic              outReady,
  output logic [ADDR_W-1:0] outAddr,
  output logic [DATA_W-1:0] outData,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(READ_WAIT - 1);
  localparam logic [ADDR_W-1:0] FIRST_A  = ADDR_W'(REG_FIRST);
  localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(REG_LAST);

  scanState_t        state, stateNext;
  logic [CNT_W-1:0]  cnt, cntNext;
  logic [ADDR_W-1:0] regAddrNext, outAddrNext;
  logic [DATA_W-1:0] outDataNext;
  logic              outValidNext, busyNext, doneNext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      regAddr  <= FIRST_A;
      outValid <= 1'b0;
      outAddr  <= '0;
      outData  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= stateNext;
      cnt      <= cntNext;
      regAddr  <= regAddrNext;
      outValid <= outValidNext;
      outAddr  <= outAddrNext;
      outData  <= outDataNext;
      busy     <= busyNext;
      done     <= doneNext;
    end
  end

  always_comb begin
    stateNext    = state;
    cntNext      = cnt;
    regAddrNext  = regAddr;
    outValidNext = outValid;
    outAddrNext  = outAddr;
    outDataNext  = outData;
    busyNext     = busy;
    doneNext     = 1'b0;

    // abort outranks every in-flight action, including a pending handshake
    if (abort && (state != ST_IDLE)) begin
      stateNext    = ST_IDLE;
      regAddrNext  = FIRST_A;
      outValidNext = 1'b0;
      busyNext     = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          regAddrNext = FIRST_A;
          if (start && !abort) begin
            stateNext = ST_WAIT;
            cntNext   = CNT_LOAD;
            busyNext  = 1'b1;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            outValidNext = 1'b1;
            outAddrNext  = regAddr;
            outDataNext  = regData;
            stateNext    = ST_SEND;
          end else begin
            cntNext = cnt - CNT_W'(1);
          end
        end
        ST_SEND: begin
          if (outReady) begin
            outValidNext = 1'b0;
            // terminate on the last index rather than relying on wrap-around
            if (regAddr == LAST_A) begin
              stateNext = ST_DONE;
              doneNext  = 1'b1;
            end else begin
              regAddrNext = regAddr + ADDR_W'(1);
              cntNext     = CNT_LOAD;
              stateNext   = ST_WAIT;
            end
          end
        end
        ST_DONE: begin
          busyNext    = 1'b0;
          regAddrNext = FIRST_A;
          stateNext   = ST_IDLE;
        end
        default: stateNext = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sm_reg_scanner.sv
// tb/tb_sm_reg_scanner.sv - randomized model-checked bench for sm_reg_scanner
module tb_sm_reg_scanner;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NI = 2;

  function automatic int pFirst(int k); return (k == 0) ? 0 : 10;  endfunction
  function automatic int pLast(int k);  return (k == 0) ? 31 : 10; endfunction
  function automatic int pWait(int k);  return (k == 0) ? 1 : 3;   endfunction

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0, abort = 1'b0, outReady = 1'b0;
  logic [DW-1:0] noise = '0;
  logic [DW-1:0] rf [32];

  logic [AW-1:0] regAddr0, outAddr0, regAddr1, outAddr1;
  logic [DW-1:0] regData0, outData0, regData1, outData1;
  logic outValid0, busy0, done0, outValid1, busy1, done1;

  // data is deliberately scrambled while a beat is pending, so a late capture shows up
  assign regData0 = outValid0 ? noise : rf[regAddr0];
  assign regData1 = outValid1 ? noise : rf[regAddr1];

  sm_reg_scanner #(.ADDR_W(AW), .DATA_W(DW), .REG_FIRST(0), .REG_LAST(31), .READ_WAIT(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .regAddr(regAddr0), .regData(regData0), .outValid(outValid0), .outReady(outReady),
    .outAddr(outAddr0), .outData(outData0), .busy(busy0), .done(done0));

  sm_reg_scanner #(.ADDR_W(AW), .DATA_W(DW), .REG_FIRST(10), .REG_LAST(10), .READ_WAIT(3)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .regAddr(regAddr1), .regData(regData1), .outValid(outValid1), .outReady(outReady),
    .outAddr(outAddr1), .outData(outData1), .busy(busy1), .done(done1));

  always #5 clk = ~clk;

  int nAssert = 0;
  int nFail = 0;
  bit chkEn = 0;
  int beats0 = 0, beats1 = 0, doneCnt0 = 0, doneCnt1 = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // transaction-level model: which index is presented, how long it has been presented,
  // and whether a captured beat is waiting for the sink
  int            mIdx [NI];
  int            mAge [NI];
  bit            mBusy [NI], mValid [NI], mDone [NI], mFinishing [NI];
  logic [AW-1:0] mAddr [NI];
  logic [DW-1:0] mData [NI];

  function automatic void modelReset();
    for (int k = 0; k < NI; k++) begin
      mIdx[k] = pFirst(k); mAge[k] = 0; mBusy[k] = 0; mValid[k] = 0;
      mDone[k] = 0; mFinishing[k] = 0; mAddr[k] = '0; mData[k] = '0;
    end
    chkEn = 1;
  endfunction

  function automatic void modelStep();
    for (int k = 0; k < NI; k++) begin
      mDone[k] = 0;
      if (mBusy[k] && abort) begin
        mBusy[k] = 0; mValid[k] = 0; mFinishing[k] = 0; mIdx[k] = pFirst(k);
      end else if (mFinishing[k]) begin
        mFinishing[k] = 0; mBusy[k] = 0; mIdx[k] = pFirst(k);
      end else if (!mBusy[k]) begin
        if (start && !abort) begin mBusy[k] = 1; mAge[k] = 0; end
      end else if (mValid[k]) begin
        if (outReady) begin
          mValid[k] = 0;
          if (mIdx[k] == pLast(k)) begin mFinishing[k] = 1; mDone[k] = 1; end
          else begin mIdx[k]++; mAge[k] = 0; end
        end
      end else begin
        mAge[k]++;
        if (mAge[k] == pWait(k)) begin
          mValid[k] = 1; mAddr[k] = AW'(mIdx[k]); mData[k] = rf[mIdx[k]];
        end
      end
    end
  endfunction

  function automatic void cmpOne(int k, logic [AW-1:0] ra, logic ov, logic [AW-1:0] oa,
                                 logic [DW-1:0] od, logic b, logic d);
    chk($sformatf("i%0d_regAddr", k), 64'(ra), 64'(mIdx[k]));
    chk($sformatf("i%0d_outValid", k), 64'(ov), 64'(mValid[k]));
    chk($sformatf("i%0d_busy", k), 64'(b), 64'(mBusy[k]));
    chk($sformatf("i%0d_done", k), 64'(d), 64'(mDone[k]));
    if (mValid[k]) begin
      chk($sformatf("i%0d_outAddr", k), 64'(oa), 64'(mAddr[k]));
      chk($sformatf("i%0d_outData", k), 64'(od), 64'(mData[k]));
    end
  endfunction

  always @(negedge clk) begin
    if (chkEn) begin
      cmpOne(0, regAddr0, outValid0, outAddr0, outData0, busy0, done0);
      cmpOne(1, regAddr1, outValid1, outAddr1, outData1, busy1, done1);
      if (rst_n && outValid0 && outReady && !abort) beats0++;
      if (rst_n && outValid1 && outReady && !abort) beats1++;
      if (done0) doneCnt0++;
      if (done1) doneCnt1++;
    end
  end

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
    noise = $urandom();
  endtask

  task automatic doReset(int n);
    rst_n = 1'b0;
    modelReset();
    repeat (n) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic runToDone(string name);
    bit seen = 0;
    for (int t = 0; t < 300; t++) begin
      tick();
      if (done0) begin seen = 1; break; end
    end
    chk({name, "_done_seen"}, 64'(seen), 64'd1);
    tick(); tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int first0, first1;
    bit found;
    for (int i = 0; i < 32; i++) rf[i] = DW'(i) * 32'h1111_1111;

    // reset state
    #2;
    doReset(4);
    chk("rst_regAddr", 64'(regAddr0), 64'd0);
    chk("rst_outValid", 64'(outValid0), 64'd0);
    chk("rst_outAddr", 64'(outAddr0), 64'd0);
    chk("rst_outData", 64'(outData0), 64'd0);
    chk("rst_busy_done", 64'({busy0, done0}), 64'd0);
    chk("rst_regAddr_i1", 64'(regAddr1), 64'd10);

    // full scan with the sink always ready; instance 1 runs its single-beat scan alongside
    outReady = 1'b1; beats0 = 0; beats1 = 0; doneCnt0 = 0; doneCnt1 = 0;
    first0 = -1; first1 = -1;
    start = 1'b1;
    for (int t = 1; t <= 200; t++) begin
      tick();
      start = 1'b0;
      if (outValid0 && first0 < 0) first0 = t;
      if (outValid1 && first1 < 0) first1 = t;
      if (outValid0 && outAddr0 == 5'd5) chk("data_addr5", 64'(outData0), 64'h5555_5555);
      if (done0) break;
    end
    tick(); tick();
    chk("first_valid_latency", 64'(first0), 64'd2);
    chk("first_valid_latency_i1", 64'(first1), 64'd4);
    chk("full_scan_beats", 64'(beats0), 64'd32);
    chk("single_scan_beats_i1", 64'(beats1), 64'd1);
    chk("full_scan_done_pulses", 64'(doneCnt0), 64'd1);
    chk("single_scan_done_i1", 64'(doneCnt1), 64'd1);
    chk("busy_after_scan", 64'(busy0), 64'd0);

    // backpressure on beat 3
    beats0 = 0; found = 0;
    start = 1'b1;
    for (int t = 0; t < 100; t++) begin
      tick(); start = 1'b0;
      if (outValid0 && outAddr0 == 5'd3) begin found = 1; break; end
    end
    chk("bp_reach_beat3", 64'(found), 64'd1);
    outReady = 1'b0;
    for (int t = 0; t < 5; t++) begin
      tick();
      chk("bp_hold_valid", 64'(outValid0), 64'd1);
      chk("bp_hold_addr", 64'(outAddr0), 64'd3);
      chk("bp_hold_data", 64'(outData0), 64'h3333_3333);
      chk("bp_hold_regAddr", 64'(regAddr0), 64'd3);
    end
    outReady = 1'b1;
    runToDone("bp");
    chk("bp_scan_beats", 64'(beats0), 64'd32);

    // abort while beat 10 is pending
    doneCnt0 = 0; found = 0;
    start = 1'b1;
    for (int t = 0; t < 100; t++) begin
      tick(); start = 1'b0;
      if (outValid0 && outAddr0 == 5'd10) begin found = 1; break; end
    end
    chk("abort_reach_beat10", 64'(found), 64'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_outValid", 64'(outValid0), 64'd0);
    chk("abort_busy", 64'(busy0), 64'd0);
    chk("abort_regAddr", 64'(regAddr0), 64'd0);
    tick(); tick(); tick();
    chk("abort_no_done", 64'(doneCnt0), 64'd0);
    found = 0;
    start = 1'b1;
    for (int t = 0; t < 20; t++) begin
      tick(); start = 1'b0;
      if (outValid0) begin found = 1; break; end
    end
    chk("restart_first_addr", 64'({found, outAddr0}), 64'({1'b1, 5'd0}));
    runToDone("restart");

    // reset mid-scan
    doneCnt0 = 0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (9) tick();
    doReset(2);
    chk("midrst_busy_valid", 64'({busy0, outValid0}), 64'd0);
    tick(); tick();
    chk("midrst_no_done", 64'(doneCnt0), 64'd0);

    // redundant start pulses during the scan and in the DONE cycle
    beats0 = 0; doneCnt0 = 0; found = 0;
    start = 1'b1;
    for (int t = 1; t < 300; t++) begin
      tick();
      start = (t % 7 == 0);
      if (done0) begin
        found = 1;
        start = 1'b1; tick(); start = 1'b0;
        break;
      end
    end
    start = 1'b0;
    repeat (4) tick();
    chk("dup_start_done_seen", 64'(found), 64'd1);
    chk("dup_start_beats", 64'(beats0), 64'd32);
    chk("dup_start_done_pulses", 64'(doneCnt0), 64'd1);
    chk("dup_start_idle", 64'(busy0), 64'd0);

    // randomized traffic against the model
    for (int i = 0; i < 32; i++) rf[i] = $urandom();
    for (int t = 0; t < 4000; t++) begin
      start    = ($urandom_range(0, 11) == 0);
      abort    = ($urandom_range(0, 79) == 0);
      outReady = ($urandom_range(0, 9) < 7);
      if (!busy0 && !busy1 && $urandom_range(0, 3) == 0) rf[$urandom_range(0, 31)] = $urandom();
      if ($urandom_range(0, 999) == 0) doReset(2);
      tick();
    end
    start = 1'b0; abort = 1'b0; outReady = 1'b1;
    repeat (100) tick();
    chk("final_idle", 64'({busy0, busy1}), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
